alu_iterative_ex: RTL and testbench
===================================

Name: alu_iterative_ex

Overview:
- Execute-stage ALU that consumes the 6-bit ALU control code produced upstream, plus the two 32-bit operands.
- Produces the 32-bit result and the branch-taken flag.
- Non-shift ops complete in one cycle. Shifts (SLL/SRL/SRA) run iteratively, SHIFT_STEP bits per cycle, to save area.
- A valid/ready handshake on both sides lets the hazard unit stall fetch/decode while a shift is in flight.

Parameters:
- SHIFT_STEP, 4, bits shifted per iteration cycle; legal values 1, 2, 4, 8, 16.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of the in-flight or held op (branch mispredict / trap)
- in_valid  in  1  operands and control are valid
- in_ready  out  1  block can accept this cycle
- alu_ctrl  in  6  ALU control code
- op_a  in  32  operand A (rs1, or PC+4 for JAL/JALR)
- op_b  in  32  operand B (rs2 or immediate); shamt = op_b[4:0]
- out_valid  out  1  result/branch_taken valid
- out_ready  in  1  downstream (EX/MEM register) accepts
- result  out  32  ALU result
- branch_taken  out  1  branch condition true

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset (async, immediate): state IDLE, out_valid=0, result=0, branch_taken=0, internal accumulator and counter=0.
- Reset mid-shift abandons the op; no output is ever produced for it.
- Accept: fires when in_valid && in_ready at a rising edge (cycle N).
- Code map {000,f3}:
  - 000 ADD, 001 SLL, 010 SLT (signed), 011 SLTU
  - 100 XOR, 101 SRL, 110 OR, 111 AND
- Code map {001,f3}: 000 SUB, 101 SRA.
- Code map {010,f3}: branches.
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
  - branch_taken = condition; result=0.
- Code 011_111: result = op_a (pass).
- Any other code: result=0, branch_taken=0, 1-cycle latency.
- branch_taken=0 for all non-branch codes. SLT/SLTU result is 0 or 1, zero-extended. Arithmetic wraps modulo 2^32; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> DONE on accept of a non-shift op, or a shift with shamt=0 (result = op_a).
  - IDLE -> SHIFT on accept of a shift with shamt!=0: acc=op_a, rem=shamt, op latched.
  - SHIFT: each cycle shift acc by k=min(SHIFT_STEP, rem) (SRA sign-fills from acc[31]); rem -= k. When rem reaches 0, go to DONE with result=acc.
  - DONE: out_valid=1; outputs held stable until out_ready. On out_ready, go to IDLE, or directly reaccept if a new op is accepted the same cycle.
- Latency from accept cycle N to out_valid:
  - 1 cycle for non-shift ops and shamt=0
  - 1+ceil(shamt/SHIFT_STEP) cycles for shifts with shamt!=0
- in_ready = (state==IDLE) || (state==DONE && out_ready); forced 0 when flush=1.
- Back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
- Operands and control are sampled only at accept. Input changes during SHIFT/DONE are ignored.
- flush=1 at an edge:
  - state -> IDLE; out_valid=0 next cycle; in-flight/held op discarded.
  - flush has priority over accept and over the DONE->IDLE handoff.
  - result/branch_taken may keep stale values while out_valid=0.
- out_valid never drops without a handshake or a flush. result/branch_taken are constant while out_valid && !out_ready.

Test Plan:
- Reset then single ops, out_ready=1.
  - ADD 0x7FFFFFFF+1 -> 0x80000000
  - SUB 5-7 -> 0xFFFFFFFE
  - SLT 0xFFFFFFFF,1 -> 1
  - SLTU same operands -> 0
  - Each: out_valid exactly 1 cycle after accept, in_ready stays 1.
- Branches:
  - BLT op_a=0xFFFFFFFF, op_b=1 -> branch_taken=1
  - BLTU same -> 0
  - BEQ 0x10,0x10 -> 1; BNE same -> 0
  - pass code 011_111, op_a=0x00001004 -> result 0x00001004, branch_taken=0
- Shifts, SHIFT_STEP=4:
  - SRA 0x80000000 by 5 -> 0xFC000000, out_valid 3 cycles after accept, in_ready=0 meanwhile
  - SLL 1 by 31 -> 0x80000000, latency 9
  - SRL by 0 -> op_a unchanged, latency 1
- Backpressure: out_ready=0 for 4 cycles on an AND result -> out_valid, result, branch_taken held, in_ready=0. Raise out_ready with in_valid=1 -> new op accepted same cycle; next result appears the following cycle.
- Flush: flush on the second SHIFT cycle of SLL by 20 -> out_valid never rises for it, in_ready=1 next cycle. Flush asserted together with in_valid in IDLE -> op not accepted.
- Async reset: assert rst mid-shift, between clock edges -> out_valid=0 and in_ready=1 immediately, with no clock edge needed. After release, a fresh ADD completes with latency 1.

Source files
------------

// File: rtl/alu_iterative_ex_if.sv
// alu_iterative_ex_if: issue/result handshake bundle between the pipeline and the iterative execute ALU
interface alu_iterative_ex_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  modport master (
    output flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );
  modport slave (
    input  flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_iterative_ex.sv
// alu_iterative_ex: execute-stage ALU, single-cycle ops plus iterative SHIFT_STEP-bit-per-cycle shifts
module alu_iterative_ex #(
  parameter int SHIFT_STEP = 4
) (
  input logic               clk,
  input logic               rst,
  alu_iterative_ex_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] K_NONE = 2'd0, K_SLL = 2'd1, K_SRL = 2'd2, K_SRA = 2'd3;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t      r_state, w_next;
  logic [31:0] r_acc, r_result, w_res, w_sra, w_shifted;
  logic [4:0]  r_rem, w_k, w_rem_nxt;
  logic [1:0]  r_kind, w_kind;
  logic        r_branch, w_br, w_ready, w_accept, w_lt, w_ltu, w_eq;
  assign w_lt  = $signed(bus.op_a) < $signed(bus.op_b);
  assign w_ltu = bus.op_a < bus.op_b;
  assign w_eq  = bus.op_a == bus.op_b;
  assign w_kind = bus.alu_ctrl == 6'o01 ? K_SLL :
                  bus.alu_ctrl == 6'o05 ? K_SRL :
                  bus.alu_ctrl == 6'o15 ? K_SRA : K_NONE;
  always_comb begin
    case (bus.alu_ctrl)
      6'o00:                      w_res = bus.op_a + bus.op_b;
      6'o01, 6'o05, 6'o15, 6'o37: w_res = bus.op_a;
      6'o02:                      w_res = {31'b0, w_lt};
      6'o03:                      w_res = {31'b0, w_ltu};
      6'o04:                      w_res = bus.op_a ^ bus.op_b;
      6'o06:                      w_res = bus.op_a | bus.op_b;
      6'o07:                      w_res = bus.op_a & bus.op_b;
      6'o10:                      w_res = bus.op_a - bus.op_b;
      default:                    w_res = 32'b0;
    endcase
  end
  assign w_br = bus.alu_ctrl[5:3] == 3'o2 &&
                (bus.alu_ctrl[2:0] == 3'o0 ? w_eq  :
                 bus.alu_ctrl[2:0] == 3'o1 ? !w_eq :
                 bus.alu_ctrl[2:0] == 3'o4 ? w_lt  :
                 bus.alu_ctrl[2:0] == 3'o5 ? !w_lt :
                 bus.alu_ctrl[2:0] == 3'o6 ? w_ltu :
                 bus.alu_ctrl[2:0] == 3'o7 ? !w_ltu : 1'b0);
  assign w_k       = r_rem < STEP ? r_rem : STEP;
  assign w_rem_nxt = r_rem - w_k;
  // kept out of the ternary below so the arithmetic shift stays signed
  assign w_sra     = $signed(r_acc) >>> w_k;
  assign w_shifted = r_kind == K_SLL ? r_acc << w_k :
                     r_kind == K_SRL ? r_acc >> w_k : w_sra;
  assign w_ready  = !bus.flush && (r_state == IDLE || (r_state == DONE && bus.out_ready));
  assign w_accept = bus.in_valid && w_ready;
  assign w_next = bus.flush ? IDLE :
                  w_accept ? ((w_kind != K_NONE && bus.op_b[4:0] != 5'd0) ? SHIFT : DONE) :
                  (r_state == DONE && bus.out_ready) ? IDLE :
                  (r_state == SHIFT && w_rem_nxt == 5'd0) ? DONE : r_state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= 32'b0;
      r_rem    <= 5'd0;
      r_kind   <= K_NONE;
      r_result <= 32'b0;
      r_branch <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc    <= bus.op_a;
        r_rem    <= bus.op_b[4:0];
        r_kind   <= w_kind;
        r_result <= w_res;
        r_branch <= w_br;
      end else if (r_state == SHIFT) begin
        r_acc    <= w_shifted;
        r_rem    <= w_rem_nxt;
        r_result <= w_shifted;
      end
    end
  end
  assign bus.in_ready     = w_ready;
  assign bus.out_valid    = r_state == DONE;
  assign bus.result       = r_result;
  assign bus.branch_taken = r_branch;
endmodule

// File: tb/tb_alu_iterative_ex.sv
// tb_alu_iterative_ex: randomized and directed self-checking bench for alu_iterative_ex against a behavioural model
module tb_alu_iterative_ex;
  localparam int STEP = 4;
  logic clk, rst;
  int n_vec = 0, n_err = 0;
  alu_iterative_ex_if bus();
  alu_iterative_ex #(.SHIFT_STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [32:0] model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    logic        br;
    sh = b[4:0];
    r  = 32'b0;
    br = 1'b0;
    case (c)
      6'o00: r = a + b;
      6'o10: r = a - b;
      6'o01: r = a << sh;
      6'o05: r = a >> sh;
      6'o15: r = $signed(a) >>> sh;
      6'o02: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'o03: r = (a < b) ? 32'd1 : 32'd0;
      6'o04: r = a ^ b;
      6'o06: r = a | b;
      6'o07: r = a & b;
      6'o37: r = a;
      6'o20: br = a == b;
      6'o21: br = a != b;
      6'o24: br = $signed(a) < $signed(b);
      6'o25: br = $signed(a) >= $signed(b);
      6'o26: br = a < b;
      6'o27: br = a >= b;
      default: ;
    endcase
    return {br, r};
  endfunction
  function automatic int lat_model(input logic [5:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    return ((c == 6'o01 || c == 6'o05 || c == 6'o15) && sh != 0) ? 1 + (sh + STEP - 1) / STEP : 1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string nm, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int exp_lat, lat;
    exp = model(c, a, b);
    exp_lat = lat_model(c, b);
    bus.alu_ctrl = c;
    bus.op_a = a;
    bus.op_b = b;
    bus.in_valid = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_at_issue: got %b want 1", nm, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 6'($urandom);
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s in_ready_while_busy: got %b want 0", nm, bus.in_ready);
      end
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
    end
    n_vec++;
    if (bus.result !== exp[31:0]) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", nm, bus.result, exp[31:0]);
    end
    n_vec++;
    if (bus.branch_taken !== exp[32]) begin
      n_err++;
      $display("FAIL %s branch_taken: got %b want %b", nm, bus.branch_taken, exp[32]);
    end
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain out_valid: got %b want 0", bus.out_valid);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_ctrl = 6'd0;
    bus.op_a = 32'd0;
    bus.op_b = 32'd0;
    #3;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.branch_taken !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b res=%h br=%b ir=%b want 0 0 0 1",
               bus.out_valid, bus.result, bus.branch_taken, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single();
    run_op("ADD", 6'o00, 32'h7FFF_FFFF, 32'h1);
    run_op("SUB", 6'o10, 32'd5, 32'd7);
    run_op("SLT", 6'o02, 32'hFFFF_FFFF, 32'h1);
    run_op("SLTU", 6'o03, 32'hFFFF_FFFF, 32'h1);
  endtask
  task automatic test_branch();
    run_op("BLT", 6'o24, 32'hFFFF_FFFF, 32'h1);
    run_op("BLTU", 6'o26, 32'hFFFF_FFFF, 32'h1);
    run_op("BEQ", 6'o20, 32'h10, 32'h10);
    run_op("BNE", 6'o21, 32'h10, 32'h10);
    run_op("PASS", 6'o37, 32'h0000_1004, 32'hDEAD_BEEF);
  endtask
  task automatic test_shift();
    run_op("SRA5", 6'o15, 32'h8000_0000, 32'd5);
    run_op("SLL31", 6'o01, 32'h1, 32'd31);
    run_op("SRL0", 6'o05, 32'hA5A5_1234, 32'hFFFF_FFE0);
  endtask
  task automatic test_random();
    logic [5:0] codes [20];
    logic [31:0] a, b;
    codes = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07, 6'o10, 6'o15,
              6'o20, 6'o21, 6'o24, 6'o25, 6'o26, 6'o27, 6'o37, 6'o11, 6'o22, 6'o77};
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("RAND", codes[$urandom_range(0, 19)], a, b);
    end
  endtask
  task automatic test_backpressure();
    drain();
    bus.out_ready = 1'b0;
    bus.alu_ctrl = 6'o07;
    bus.op_a = 32'hF0F0_F0F0;
    bus.op_b = 32'h3C3C_3C3C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h3030_3030 || bus.branch_taken !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got ov=%b res=%h br=%b want 1 30303030 0",
                 i, bus.out_valid, bus.result, bus.branch_taken);
      end
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_in_ready cycle %0d: got %b want 0", i, bus.in_ready);
      end
      tick();
    end
    bus.alu_ctrl = 6'o00;
    bus.op_a = 32'd3;
    bus.op_b = 32'd4;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd7) begin
      n_err++;
      $display("FAIL bp_next_result: got ov=%b res=%h want 1 00000007", bus.out_valid, bus.result);
    end
    drain();
  endtask
  task automatic test_flush();
    bit seen;
    bus.alu_ctrl = 6'o01;
    bus.op_a = 32'h1;
    bus.op_b = 32'd20;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_in_ready_low: got %b want 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_in_ready_after: got %b want 1", bus.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= bus.out_valid;
      tick();
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_shift_output: got out_valid=1 want 0");
    end
    bus.alu_ctrl = 6'o00;
    bus.op_a = 32'd9;
    bus.op_b = 32'd9;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_accept: got out_valid=%b want 0", bus.out_valid);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_done_priority: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
  endtask
  task automatic test_async_reset();
    bit seen;
    bus.alu_ctrl = 6'o01;
    bus.op_a = 32'h1;
    bus.op_b = 32'd31;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: got ov=%b ir=%b res=%h want 0 1 00000000",
               bus.out_valid, bus.in_ready, bus.result);
    end
    #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= bus.out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_abandon: got out_valid=1 want 0");
    end
    run_op("ADD_after_rst", 6'o00, 32'h1234_5678, 32'h1111_1111);
    drain();
  endtask
  initial begin
    test_reset();
    test_single();
    test_branch();
    test_shift();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
